// File: rtl/threedo_pkg.sv
// Shared definitions for the 3DO controller chain emulator: FSM states,
// chain length helper and the terminator level driven after the last pad.
package threedo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_SHIFT = 2'd2,
      ST_TAIL  = 2'd3
   } state_t;

   localparam logic TERM_LEVEL = 1'b0;

   function automatic int TOTAL_BITS(input int pads, input int bits);
      return pads * bits;
   endfunction

endpackage

// File: rtl/pin_sync.sv
// Multi-stage synchroniser for one asynchronous console pin, with edge
// detection taken from the last two synchronised samples.
module pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_last;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= '0;
         r_last <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
         r_last <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_last;
   assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_last;

endmodule

// File: rtl/threedo_chain_out.sv
// Emulates a daisy chain of PADS 3DO controllers: latches all button words on
// PS, shifts them out active-low MSB first, then passes through or terminates.
module threedo_chain_out
   import threedo_pkg::*;
#(
   parameter int BITS        = 16,
   parameter int PADS        = 2,
   parameter int SYNC_STAGES = 2,
   parameter int PASSTHRU    = 1
) (
   input  logic                                system_clock,
   input  logic                                system_reset,
   input  logic                                ps,
   input  logic                                clk,
   input  logic                                dat_in,
   input  logic [PADS*BITS-1:0]                i,
   output logic                                dat,
   output logic                                busy,
   output logic                                frame_done,
   output logic [$clog2(PADS*BITS+1)-1:0]      bit_index
);

   localparam int TOTAL = TOTAL_BITS(PADS, BITS);
   localparam int IW    = $clog2(TOTAL + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);

   logic w_ps, w_ps_rise, w_ps_fall;
   logic w_clk, w_clk_rise, w_clk_fall;
   logic w_din, w_din_rise, w_din_fall;
   logic w_unused;

   pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ps_sync (
      .i_clk(system_clock), .i_rst(system_reset), .i_pin(ps),
      .o_level(w_ps), .o_rise(w_ps_rise), .o_fall(w_ps_fall)
   );

   pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
      .i_clk(system_clock), .i_rst(system_reset), .i_pin(clk),
      .o_level(w_clk), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
   );

   pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_din_sync (
      .i_clk(system_clock), .i_rst(system_reset), .i_pin(dat_in),
      .o_level(w_din), .o_rise(w_din_rise), .o_fall(w_din_fall)
   );

   assign w_unused = ^{w_ps_rise, w_ps_fall, w_clk, w_clk_fall, w_din_rise, w_din_fall};

   state_t            r_state;
   logic [TOTAL-1:0]  r_sreg;
   logic [IW-1:0]     r_idx;
   logic              r_dat, r_busy, r_fd;
   logic [TOTAL-1:0]  w_shifted;
   logic              w_tail_dat;

   assign w_shifted  = r_sreg << 1;
   assign w_tail_dat = (PASSTHRU != 0) ? w_din : TERM_LEVEL;

   always_ff @(posedge system_clock) begin
      if (system_reset) begin
         r_state <= ST_IDLE;
         r_sreg  <= '0;
         r_idx   <= '0;
         r_dat   <= 1'b1;
         r_busy  <= 1'b0;
         r_fd    <= 1'b0;
      end else begin
         r_fd <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_ps) begin
                  r_state <= ST_LATCH;
                  r_sreg  <= i;
               end
            end
            // A clk edge coincident with the ps fall is dropped here on purpose.
            ST_LATCH: begin
               if (w_ps) begin
                  r_sreg <= i;
               end else begin
                  r_state <= ST_SHIFT;
                  r_busy  <= 1'b1;
                  r_dat   <= ~r_sreg[TOTAL-1];
               end
            end
            ST_SHIFT: begin
               if (w_ps) begin
                  r_state <= ST_LATCH;
                  r_sreg  <= i;
                  r_idx   <= '0;
                  r_busy  <= 1'b0;
                  r_dat   <= 1'b1;
               end else if (w_clk_rise) begin
                  r_sreg <= w_shifted;
                  r_idx  <= r_idx + IW'(1);
                  if (r_idx == LAST_IDX) begin
                     r_state <= ST_TAIL;
                     r_fd    <= 1'b1;
                     r_busy  <= 1'b0;
                     r_dat   <= w_tail_dat;
                  end else begin
                     r_dat <= ~w_shifted[TOTAL-1];
                  end
               end
            end
            ST_TAIL: begin
               if (w_ps) begin
                  r_state <= ST_LATCH;
                  r_sreg  <= i;
                  r_idx   <= '0;
                  r_dat   <= 1'b1;
               end else begin
                  r_dat <= w_tail_dat;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign dat        = r_dat;
   assign busy       = r_busy;
   assign frame_done = r_fd;
   assign bit_index  = r_idx;

endmodule

// File: tb/tb_threedo_chain_out.sv
// Scoreboard bench for threedo_chain_out: a PASSTHRU=1 and a PASSTHRU=0 copy
// share the pins; stimulus queues expected states, a negedge monitor checks them.
module tb_threedo_chain_out;

   logic        system_clock = 1'b0;
   logic        system_reset = 1'b1;
   logic        ps = 1'b0, clk = 1'b0, dat_in = 1'b1;
   logic [31:0] i = '0;
   logic        dat1, busy1, fd1, dat0, busy0, fd0;
   logic [5:0]  idx1, idx0;

   always #5 system_clock = ~system_clock;

   threedo_chain_out #(.BITS(16), .PADS(2), .SYNC_STAGES(2), .PASSTHRU(1)) dut (
      .system_clock(system_clock), .system_reset(system_reset),
      .ps(ps), .clk(clk), .dat_in(dat_in), .i(i),
      .dat(dat1), .busy(busy1), .frame_done(fd1), .bit_index(idx1)
   );

   threedo_chain_out #(.BITS(16), .PADS(2), .SYNC_STAGES(2), .PASSTHRU(0)) dut0 (
      .system_clock(system_clock), .system_reset(system_reset),
      .ps(ps), .clk(clk), .dat_in(dat_in), .i(i),
      .dat(dat0), .busy(busy0), .frame_done(fd0), .bit_index(idx0)
   );

   typedef struct {
      int    cyc;
      string nm;
      logic  dat;
      logic  dat0;
      logic  busy;
      int    idx;
      int    fd;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_cmp = 0, n_bad = 0;
   int   fd_cnt1 = 0, fd_cnt0 = 0;
   int   exp_fd = 0;

   always @(posedge system_clock) cyc <= cyc + 1;

   // Monitor: counts frame_done pulses and retires scoreboard entries due now.
   always @(negedge system_clock) begin
      exp_t e;
      if (fd1) fd_cnt1++;
      if (fd0) fd_cnt0++;
      if (fd1 || fd0) begin
         n_cmp++;
         if ((fd1 && busy1) || (fd0 && busy0)) begin
            n_bad++;
            $display("FAIL busy_at_done: busy=%0b/%0b while frame_done=%0b/%0b, want busy=0", busy1, busy0, fd1, fd0);
         end
      end
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         n_cmp++;
         if (dat1 !== e.dat || dat0 !== e.dat0 || busy1 !== e.busy || busy0 !== e.busy ||
             int'(idx1) != e.idx || int'(idx0) != e.idx || fd_cnt1 != e.fd || fd_cnt0 != e.fd) begin
            n_bad++;
            $display("FAIL %s @%0d: got dat=%0b/%0b busy=%0b/%0b idx=%0d/%0d fd=%0d/%0d, want dat=%0b/%0b busy=%0b idx=%0d fd=%0d",
                     e.nm, cyc, dat1, dat0, busy1, busy0, idx1, idx0, fd_cnt1, fd_cnt0,
                     e.dat, e.dat0, e.busy, e.idx, e.fd);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge system_clock);
         #1;
      end
   endtask

   task automatic expect_now(input string nm, input logic d, input logic d0,
                             input logic b, input int idx);
      exp_t e;
      e.cyc = cyc; e.nm = nm; e.dat = d; e.dat0 = d0; e.busy = b; e.idx = idx; e.fd = exp_fd;
      sb.push_back(e);
   endtask

   // clk pulse; state checked once the synchronised edge has been acted on.
   task automatic clk_edge(input string nm, input logic d, input logic d0,
                           input logic b, input int idx);
      clk = 1'b1;
      tick(3);
      expect_now(nm, d, d0, b, idx);
      clk = 1'b0;
      tick(3);
   endtask

   task automatic start_frame(input logic [31:0] w);
      i  = w;
      ps = 1'b1;
      tick(4);
      expect_now("latch", 1'b1, 1'b1, 1'b0, 0);
      ps = 1'b0;
      tick(3);
      expect_now("first_bit", ~w[31], ~w[31], 1'b1, 0);
   endtask

   task automatic shift_bits(input string nm, input logic [31:0] w, input int from, input int to);
      logic b;
      for (int k = from; k <= to; k++) begin
         b = ~w[31-k];
         clk_edge(nm, b, b, 1'b1, k);
      end
   endtask

   initial begin
      logic [31:0] w1, wa, wb, wc;
      w1 = 32'h8001_00FF;
      wa = 32'hA5A5_3C3C;
      wb = 32'h1234_5678;
      wc = 32'h4000_0001;

      tick(3);
      expect_now("reset", 1'b1, 1'b1, 1'b0, 0);
      system_reset = 1'b0;
      tick(2);

      // Full frame: 31 shifting edges, then the 32nd ends the local bits.
      start_frame(w1);
      shift_bits("frame1", w1, 1, 31);
      exp_fd++;
      clk_edge("edge32", dat_in, 1'b0, 1'b0, 32);

      // Tail: passthrough copy follows dat_in, terminator copy stays low.
      for (int t = 0; t < 8; t++) begin
         dat_in = t[0];
         clk_edge("tail", t[0], 1'b0, 1'b0, 32);
      end

      // Abort mid-frame; i changes during SHIFT must not disturb the frame.
      start_frame(wa);
      shift_bits("abortA", wa, 1, 3);
      i = wb;
      shift_bits("abortA_ichg", wa, 4, 10);
      ps = 1'b1;
      tick(4);
      expect_now("abort", 1'b1, 1'b1, 1'b0, 0);
      clk_edge("clk_in_latch", 1'b1, 1'b1, 1'b0, 0);
      ps = 1'b0;
      tick(3);
      expect_now("restart", ~wb[31], ~wb[31], 1'b1, 0);
      shift_bits("restartB", wb, 1, 4);

      // Reset mid-frame, then clk edges ignored in IDLE.
      start_frame(wa);
      shift_bits("preReset", wa, 1, 5);
      system_reset = 1'b1;
      tick(1);
      expect_now("midreset", 1'b1, 1'b1, 1'b0, 0);
      system_reset = 1'b0;
      tick(1);
      clk_edge("idle_clk", 1'b1, 1'b1, 1'b0, 0);
      clk_edge("idle_clk2", 1'b1, 1'b1, 1'b0, 0);

      // ps fall and clk rise in the same cycle: clk edge must not shift.
      i  = wc;
      ps = 1'b1;
      tick(4);
      ps  = 1'b0;
      clk = 1'b1;
      tick(3);
      expect_now("coinc_first", ~wc[31], ~wc[31], 1'b1, 0);
      clk = 1'b0;
      tick(3);
      expect_now("coinc_hold", ~wc[31], ~wc[31], 1'b1, 0);
      shift_bits("coinc_shift", wc, 1, 2);

      tick(3);
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
